mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 13, address width in bits, matching Main_Memory.
REQ-002 Parameter DATA_W, 13, data word width in bits.
REQ-003 Parameter TIMEOUT, 15, maximum cycles to wait for mem_done before aborting; legal range 1-255.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 if_req  in  1  instruction-fetch request; held high until if_ack.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_rdata  out  DATA_W  fetched instruction word.
REQ-009 if_ack  out  1  one-cycle fetch completion pulse.
REQ-010 d_req  in  1  data request; held high until d_ack.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  ADDR_W  data address.
REQ-013 d_wdata  in  DATA_W  store data.
REQ-014 d_rdata  out  DATA_W  load data.
REQ-015 d_ack  out  1  one-cycle data completion pulse.
REQ-016 mem_address, mem_dataIn  out  ADDR_W, DATA_W  address and write data to Main_Memory.
REQ-017 mem_read, mem_write, mem_instruction  out  1 each  Main_Memory strobes and fetch qualifier.
REQ-018 mem_dataOut  in  DATA_W  Main_Memory read data.
REQ-019 mem_done  in  1  Main_Memory completion.
REQ-020 busy  out  1  high in any state other than IDLE.
REQ-021 timeout_err  out  1  pulses together with the ack of an aborted transfer.

Function
REQ-022 The FSM SHALL have four states: IDLE, FETCH, DATA, RESP.
- IDLE -> FETCH or DATA when a request wins arbitration.
- FETCH/DATA -> RESP on mem_done or on timeout.
- RESP -> IDLE unconditionally after one cycle.
REQ-023 In IDLE, arbitration SHALL be as follows:
- Only one of if_req/d_req high: that requester is granted.
- Both high: round-robin against last_grant; the port not granted most recently wins.
- last_grant resets to DATA, so fetch wins the first tie.
REQ-024 At the grant edge, address, d_we and d_wdata SHALL be latched; later changes on requester inputs SHALL not affect the transfer in flight.
REQ-025 In FETCH, outputs SHALL be:
- mem_read=1, mem_write=0, mem_instruction=1.
- mem_address=latched if_addr.
REQ-026 In DATA, outputs SHALL be:
- mem_instruction=0, mem_address=latched d_addr.
- Load: mem_read=1, mem_write=0.
- Store: mem_write=1, mem_read=0, mem_dataIn=latched d_wdata.
REQ-027 Strobes SHALL be registered, held constant for the whole FETCH/DATA state, and 0 in IDLE and RESP.
REQ-028 mem_done SHALL be ignored outside FETCH/DATA.
REQ-029 When mem_done=1 is sampled in FETCH/DATA, the arbiter SHALL complete the transfer:
- Capture mem_dataOut on that edge: into if_rdata for a fetch, into d_rdata for a load.
- Leave d_rdata unchanged on a store.
- Enter RESP, where the matching ack is 1 for exactly that cycle.
REQ-030 if_rdata/d_rdata SHALL hold their value until overwritten by a later completing transfer.
REQ-031 A wait counter SHALL clear at grant and increment each FETCH/DATA cycle. When it reaches TIMEOUT without mem_done, the arbiter SHALL:
- Enter RESP and assert the ack with timeout_err=1.
- Load the read-data output of the aborted port with 0.
REQ-032 If mem_done and the timeout occur in the same cycle, mem_done SHALL take priority: normal completion, timeout_err=0.
REQ-033 Requests SHALL not be sampled in FETCH, DATA or RESP. A requester drops req at the edge ending its ack cycle. The minimum transfer is 3 cycles (grant, wait with mem_done=1, RESP).
REQ-034 last_grant SHALL update at each grant edge.

Reset
REQ-035 While reset=1 at a rising edge, the following SHALL hold after that edge, including when reset arrives mid-transfer; the aborted transfer SHALL produce no ack:
- State=IDLE, last_grant=DATA, wait counter=0.
- All strobes, acks, busy and timeout_err = 0.
- if_rdata=0, d_rdata=0, mem_address=0, mem_dataIn=0.

Verification
REQ-036 Lone fetch: if_req=1, if_addr=0x005; memory returns 0x1A2B with mem_done on the 2nd FETCH cycle -> mem_read=1 and mem_instruction=1 for 2 cycles, if_ack pulses in the following cycle with if_rdata=0x1A2B, busy=1 for 3 cycles.
REQ-037 Store: d_req=1, d_we=1, d_addr=0x000, d_wdata=0x10F0 -> mem_write=1 and mem_dataIn=0x10F0 until mem_done; d_ack pulses once; d_rdata unchanged.
REQ-038 Tie after reset: if_req=d_req=1 held continuously -> grant order FETCH, DATA, FETCH, DATA; no port is granted twice in a row.
REQ-039 Timeout: d_req=1 load, mem_done held 0, TIMEOUT=15 -> d_ack and timeout_err high together after 15 DATA cycles, d_rdata=0; a simultaneous mem_done at cycle 15 gives timeout_err=0.
REQ-040 Reset mid-transfer: reset=1 during FETCH -> next cycle all strobes 0, busy=0, no if_ack; after reset, a pending d_req is granted within 1 cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one Main_Memory port between an instruction-fetch requester and a
//   data (load/store) requester. Ties are broken round-robin. Each transfer
//   ends in a one-cycle RESP state carrying the requester's ack. A transfer
//   that never sees mem_done is aborted after TIMEOUT wait cycles; its ack
//   is flagged with timeout_err and its read data is returned as zero.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   if_req/if_addr    fetch request and address; if_rdata/if_ack are the result
//   d_req/d_we/...    data request, direction, address and store data;
//                     d_rdata/d_ack are the result
//   mem_*             Main_Memory address, write data, strobes, read data, done
//   busy              high whenever the FSM is not in IDLE
//   timeout_err       pulses together with the ack of an aborted transfer
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 13,
  parameter int TIMEOUT = 15   // legal range 1..255
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  // Main_Memory side
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dataIn,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_instruction,
  input  logic [DATA_W-1:0] mem_dataOut,
  input  logic              mem_done,
  // status
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

  // The wait counter reaching this value at a clock edge means the current
  // cycle is the TIMEOUT-th wait cycle, so the transfer aborts on this edge.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        last_grant_data;  // 1: data port was granted most recently
  logic [7:0]  wait_cnt;
  logic        grant_fetch, grant_data;
  logic        in_xfer;
  logic        done_ev, tmo_ev;

  assign in_xfer = (state == FETCH) || (state == DATA);
  assign done_ev = in_xfer && mem_done;
  // mem_done wins over a coincident timeout.
  assign tmo_ev  = in_xfer && !mem_done && (wait_cnt == WAIT_LAST);
  assign busy    = (state != IDLE);

  // Next-state and grant decision.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_nxt   = state;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    unique case (state)
      IDLE: begin
        if (if_req && (!d_req || last_grant_data)) begin
          grant_fetch = 1'b1;
          state_nxt   = FETCH;
        end else if (d_req) begin
          grant_data = 1'b1;
          state_nxt  = DATA;
        end
      end
      FETCH, DATA: if (done_ev || tmo_ev) state_nxt = RESP;
      RESP:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: every register, including the read-data holding registers, is
      // reset so an interrupted transfer leaves no stale result or ack behind.
      state           <= IDLE;
      last_grant_data <= 1'b1;
      wait_cnt        <= '0;
      mem_address     <= '0;
      mem_dataIn      <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_instruction <= 1'b0;
      if_rdata        <= '0;
      d_rdata         <= '0;
      if_ack          <= 1'b0;
      d_ack           <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      // Acks and timeout_err are only ever high during the single RESP cycle.
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      timeout_err <= 1'b0;

      if (grant_fetch) begin
        mem_address     <= if_addr;
        mem_read        <= 1'b1;
        mem_write       <= 1'b0;
        mem_instruction <= 1'b1;
        wait_cnt        <= '0;
        last_grant_data <= 1'b0;
      end

      if (grant_data) begin
        mem_address     <= d_addr;
        mem_read        <= !d_we;
        mem_write       <= d_we;
        mem_instruction <= 1'b0;
        if (d_we) mem_dataIn <= d_wdata;
        wait_cnt        <= '0;
        last_grant_data <= 1'b1;
      end

      if (in_xfer) begin
        if (done_ev || tmo_ev) begin
          mem_read        <= 1'b0;
          mem_write       <= 1'b0;
          mem_instruction <= 1'b0;
          timeout_err     <= tmo_ev;
          if (state == FETCH) begin
            if_ack   <= 1'b1;
            if_rdata <= done_ev ? mem_dataOut : '0;
          end else begin
            d_ack <= 1'b1;
            // mem_write still reflects the latched direction of this transfer;
            // a store leaves d_rdata untouched.
            if (!mem_write) d_rdata <= done_ev ? mem_dataOut : '0;
          end
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 13;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req, d_req, d_we, mem_done;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic [DATA_W-1:0] d_wdata, mem_dataOut;
  logic [DATA_W-1:0] if_rdata, d_rdata, mem_dataIn;
  logic [ADDR_W-1:0] mem_address;
  logic              if_ack, d_ack, mem_read, mem_write, mem_instruction;
  logic              busy, timeout_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_address(mem_address), .mem_dataIn(mem_dataIn),
    .mem_read(mem_read), .mem_write(mem_write), .mem_instruction(mem_instruction),
    .mem_dataOut(mem_dataOut), .mem_done(mem_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; if_req = 0; d_req = 0; d_we = 0; mem_done = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_dataOut = '0;
    tick(2);

    // ---- reset state ----
    check("rst_busy", busy, 0);
    check("rst_strobes", {mem_read, mem_write, mem_instruction}, 0);
    check("rst_acks", {if_ack, d_ack, timeout_err}, 0);
    check("rst_rdata", {if_rdata, d_rdata}, 0);
    check("rst_mem_addr_din", {mem_address, mem_dataIn}, 0);
    reset = 1'b0;

    // ---- lone fetch, mem_done on 2nd FETCH cycle ----
    if_req = 1; if_addr = 13'h005; mem_dataOut = 13'h1A2B;
    tick();                                  // grant edge -> FETCH 1
    if_addr = 13'h1FF;                       // must not disturb transfer
    check("f1_strobes", {mem_read, mem_write, mem_instruction}, 3'b101);
    check("f1_addr", mem_address, 13'h005);
    check("f1_busy", busy, 1);
    tick();                                  // FETCH 2
    check("f2_strobes", {mem_read, mem_write, mem_instruction}, 3'b101);
    check("f2_addr", mem_address, 13'h005);
    check("f2_no_ack", if_ack, 0);
    mem_done = 1;
    tick();                                  // RESP
    check("f_resp_ack", {if_ack, d_ack, timeout_err}, 3'b100);
    check("f_resp_rdata", if_rdata, 13'h1A2B);
    check("f_resp_strobes", {mem_read, mem_write, mem_instruction}, 0);
    check("f_resp_busy", busy, 1);
    if_req = 0; mem_done = 0;
    tick();                                  // IDLE
    check("f_idle", {busy, if_ack}, 0);

    // ---- store ----
    d_req = 1; d_we = 1; d_addr = 13'h000; d_wdata = 13'h10F0;
    mem_dataOut = 13'h0ABC;
    tick();                                  // DATA
    d_wdata = 13'h0555; d_addr = 13'h0123;
    check("st_strobes", {mem_read, mem_write, mem_instruction}, 3'b010);
    check("st_din", mem_dataIn, 13'h10F0);
    check("st_addr", mem_address, 13'h000);
    mem_done = 1;
    tick();                                  // RESP
    check("st_ack", {if_ack, d_ack, timeout_err}, 3'b010);
    check("st_rdata_kept", d_rdata, 13'h0);
    check("st_resp_strobes", {mem_read, mem_write}, 0);
    d_req = 0; d_we = 0; mem_done = 0;
    tick();
    check("st_idle", {busy, d_ack}, 0);

    // ---- tie after reset: FETCH, DATA, FETCH, DATA ----
    reset = 1; tick(); reset = 0;
    if_req = 1; d_req = 1; d_we = 0; mem_done = 1;
    for (int i = 0; i < 4; i++) begin
      mem_dataOut = 13'(13'h100 + i);
      tick();                                // grant edge
      check($sformatf("tie%0d_inst", i), mem_instruction, (i % 2 == 0));
      check($sformatf("tie%0d_read", i), mem_read, 1);
      tick();                                // RESP
      check($sformatf("tie%0d_acks", i), {if_ack, d_ack}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i % 2 == 0) check($sformatf("tie%0d_ifr", i), if_rdata, 13'h100 + i);
      else            check($sformatf("tie%0d_dr", i), d_rdata, 13'h100 + i);
      if (i < 3) tick();                     // back to IDLE
    end
    if_req = 0; d_req = 0; mem_done = 0;
    tick();
    check("tie_idle", busy, 0);

    // ---- timeout on a load ----
    d_req = 1; d_we = 0;
    tick();                                  // DATA cycle 1
    tick(TIMEOUT - 1);                       // DATA cycle 15
    check("to_last_read", {busy, mem_read}, 2'b11);
    check("to_no_ack_yet", d_ack, 0);
    tick();                                  // RESP
    check("to_ack_err", {d_ack, timeout_err}, 2'b11);
    check("to_rdata_zero", d_rdata, 0);
    d_req = 0;
    tick();
    check("to_idle", {busy, timeout_err}, 0);

    // ---- mem_done coincident with timeout ----
    d_req = 1; mem_dataOut = 13'h0777;
    tick();
    tick(TIMEOUT - 1);
    mem_done = 1;
    tick();
    check("tod_ack_err", {d_ack, timeout_err}, 2'b10);
    check("tod_rdata", d_rdata, 13'h0777);
    d_req = 0; mem_done = 0;
    tick();

    // ---- reset mid-fetch, then pending d_req ----
    if_req = 1; if_addr = 13'h0042;
    tick();                                  // FETCH
    check("rm_fetch", {mem_read, mem_instruction}, 2'b11);
    reset = 1; if_req = 0; d_req = 1; d_we = 0;
    tick();                                  // reset edge
    check("rm_strobes", {mem_read, mem_write, mem_instruction}, 0);
    check("rm_busy_ack", {busy, if_ack, d_ack}, 0);
    check("rm_regs", {mem_address, if_rdata, d_rdata}, 0);
    reset = 0;
    tick();                                  // grant of pending d_req
    check("rm_grant", {busy, mem_read, mem_instruction}, 3'b110);
    mem_done = 1; mem_dataOut = 13'h0321;
    tick();
    check("rm_ack", {if_ack, d_ack}, 2'b01);
    check("rm_rdata", d_rdata, 13'h0321);
    d_req = 0; mem_done = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
